// File: rtl/dac_sched_pkg.sv
// Shared types and command-word layout for the DAC update scheduler.
// Holds the FSM encoding and the 16-bit word builder.
package dac_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_CS,
    S_WAIT_LD,
    S_WAIT_END,
    S_ACK
  } state_e;

  localparam logic [1:0] CMD_WRITE_UPD = 2'b01;
  localparam int CH_MSB   = 15;
  localparam int CMD_MSB  = 13;
  localparam int DATA_MSB = 11;
  localparam int SAMPLE_W = DATA_MSB + 1;

  function automatic logic [15:0] mk_word(
    input logic [1:0]          ch,
    input logic [SAMPLE_W-1:0] s
  );
    logic [15:0] w;
    w = '0;
    w[CH_MSB -: 2]          = ch;
    w[CMD_MSB -: 2]         = CMD_WRITE_UPD;
    w[DATA_MSB -: SAMPLE_W] = s;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req at or after ptr.
// Produces a one-hot grant and its index.
module rr_arbiter #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0] req,
  input  logic [1:0]     ptr,
  output logic [NCH-1:0] gnt,
  output logic [1:0]     idx
);

  int             c;
  logic           found;
  logic [NCH-1:0] one_c;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    one_c = '0;
    for (int i = 0; i < NCH; i++) begin
      c     = (int'(ptr) + i) % NCH;
      one_c = NCH'(1) << c;
      if (!found && |(req & one_c)) begin
        found = 1'b1;
        gnt   = one_c;
        idx   = 2'(c);
      end
    end
  end

endmodule

// File: rtl/dac_update_scheduler.sv
// Round-robin scheduler sharing one SPI DAC link across NCH requesters.
// Optional watchdog on the CSn/LDAc handshake: DAC_SCHED_TIMEOUT_EN.
module dac_update_scheduler
  import dac_sched_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DATA_W  = 12,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  enable,
  input  logic [NCH-1:0]        req,
  input  logic [NCH*DATA_W-1:0] data_flat,
  output logic [NCH-1:0]        ack,
  output logic                  busy,
  output logic [1:0]            cur_ch,
  output logic [15:0]           spi_data,
  output logic                  spi_renew,
  output logic                  spi_dac_en,
  input  logic                  spi_csn,
  input  logic                  spi_ldac,
  output logic                  err
);

  localparam logic [1:0] LAST = 2'(NCH - 1);

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [1:0]    cur_ch_q, cur_ch_d;
  logic [15:0]   spi_data_q, spi_data_d;
  logic          dac_en_q;

  logic [NCH-1:0]      gnt;
  logic [1:0]          gidx;
  logic [DATA_W-1:0]   samp_sel;
  logic [SAMPLE_W-1:0] samp_al;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (gidx)
  );

  always_comb begin
    samp_sel = '0;
    for (int c = 0; c < NCH; c++) begin
      if (gnt[c]) samp_sel |= data_flat[c*DATA_W +: DATA_W];
    end
    samp_al = SAMPLE_W'(samp_sel) << (SAMPLE_W - DATA_W);
  end

`ifdef DAC_SCHED_TIMEOUT_EN
  localparam logic [7:0] TO8 = 8'(TIMEOUT);
  logic [7:0] wd_q, wd_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cur_ch_d   = cur_ch_q;
    spi_data_d = spi_data_q;
`ifdef DAC_SCHED_TIMEOUT_EN
    wd_d  = wd_q;
    err_d = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (enable && dac_en_q && |req) begin
          spi_data_d = mk_word(gidx, samp_al);
          cur_ch_d   = gidx;
          ptr_d      = (gidx == LAST) ? 2'd0 : gidx + 2'd1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_CS;
`ifdef DAC_SCHED_TIMEOUT_EN
        wd_d = TO8;
`endif
      end
      S_WAIT_CS: begin
        if (!spi_csn) begin
          state_d = S_WAIT_LD;
`ifdef DAC_SCHED_TIMEOUT_EN
          wd_d = TO8;
        end else if (wd_q <= 8'd1) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q - 8'd1;
`endif
        end
      end
      S_WAIT_LD: begin
        if (!spi_ldac) begin
          state_d = S_WAIT_END;
`ifdef DAC_SCHED_TIMEOUT_EN
        end else if (wd_q <= 8'd1) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q - 8'd1;
`endif
        end
      end
      S_WAIT_END: begin
        if (spi_ldac) state_d = S_ACK;
      end
      S_ACK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cur_ch_q   <= '0;
      spi_data_q <= '0;
      dac_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cur_ch_q   <= cur_ch_d;
      spi_data_q <= spi_data_d;
      dac_en_q   <= enable;
    end
  end

`ifdef DAC_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = |8'(TIMEOUT);
  assign err = 1'b0;
`endif

  assign busy       = (state_q != S_IDLE);
  assign spi_renew  = (state_q == S_ISSUE);
  assign spi_dac_en = dac_en_q;
  assign spi_data   = spi_data_q;
  assign cur_ch     = cur_ch_q;
  assign ack        = (state_q == S_ACK) ? (NCH'(1) << cur_ch_q) : '0;

endmodule
